// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake and status bundle between uart_rx and its consumer
//   data_out    : received byte, stable while data_val_o=1
//   data_val_o  : byte available, held until accepted
//   data_rdy_i  : consumer ready; transfer on data_val_o & data_rdy_i
//   frame_err_o : one-cycle pulse, stop bit sampled low
//   overrun_o   : sticky, byte completed while previous one still pending
//   master = receiver side, slave = consumer side
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_val_o;
    logic       data_rdy_i;
    logic       frame_err_o;
    logic       overrun_o;
    modport master (output data_out, data_val_o, frame_err_o, overrun_o, input data_rdy_i);
    modport slave  (input data_out, data_val_o, frame_err_o, overrun_o, output data_rdy_i);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output, framing-error and overrun flags
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   i_rx  : asynchronous serial input, idle high
//   bus   : uart_rx_if.master (data_out, data_val_o, data_rdy_i, frame_err_o, overrun_o)
//   UART_RX_MAJORITY_EN : when defined, every sample is a 2-of-3 vote around the bit centre,
//                         with all decisions taken one clock later
module uart_rx #(
    parameter int CLK_HZ = 50250000,
    parameter int BAUD   = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_rx,
    uart_rx_if.master bus
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t      r_state;
    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_sr;
    logic [7:0]  r_data_out;
    logic        r_data_val;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_bit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end
`ifdef UART_RX_MAJORITY_EN
    // The whole timebase runs one clock late, so the decision cycle sees
    // rx_s at mid+1 directly and mid / mid-1 from this short history.
    localparam int LAG = 1;
    logic [1:0] r_hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hist <= 2'b11;
        else
            r_hist <= {r_hist[0], r_rx_s};
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    localparam int LAG = 0;
    assign w_bit = r_rx_s;
`endif
    localparam logic [15:0] START_END = 16'(HALF_DIV - 1 + LAG);
    localparam logic [15:0] BIT_END   = 16'(BAUD_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sr        <= '0;
            r_data_out  <= '0;
            r_data_val  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_data_val && bus.data_rdy_i)
                r_data_val <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    // Edge, not level: a line stuck low never restarts a frame.
                    if (r_rx_d && !r_rx_s)
                        r_state <= START;
                end
                START: begin
                    if (r_cnt == START_END) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_bit ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_END) begin
                        r_cnt <= '0;
                        r_sr  <= {w_bit, r_sr[7:1]};
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == BIT_END) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (!w_bit)
                            r_frame_err <= 1'b1;
                        else if (r_data_val && !bus.data_rdy_i)
                            r_overrun <= 1'b1;
                        else begin
                            // Also covers accept-and-complete in one cycle: valid stays high.
                            r_data_out <= r_sr;
                            r_data_val <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.data_out    = r_data_out;
    assign bus.data_val_o  = r_data_val;
    assign bus.frame_err_o = r_frame_err;
    assign bus.overrun_o   = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (clean frames, glitch, framing error, overrun, reset)
module tb_uart_rx;
    localparam int BD   = 436;
    localparam int HALF = 218;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int n_del = 0;
    int fe_hi = 0;
    int val_hi = 0;
    logic [7:0] sb[$];
    uart_rx_if bus();
    uart_rx #(.CLK_HZ(50250000), .BAUD(115200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rx  (rx),
        .bus   (bus)
    );
    always #10 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err_o)
                fe_hi++;
            if (bus.data_val_o)
                val_hi++;
            if (bus.data_val_o && bus.data_rdy_i) begin
                n_del++;
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0)
                    check("rx_byte", 32'(bus.data_out), 32'(sb.pop_front()));
            end
        end
    end
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BD) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input bit exp);
        if (exp)
            sb.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        drive_bit(stop);
    endtask
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask
`ifdef UART_RX_MAJORITY_EN
    task automatic glitch_one();
        rx = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (BD - HALF - 1) @(posedge clk);
        #1;
    endtask
`endif
    initial begin
        bus.data_rdy_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_val", 32'(bus.data_val_o), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'h00);
        check("rst_fe", 32'(bus.frame_err_o), 32'd0);
        check("rst_ovr", 32'(bus.overrun_o), 32'd0);
        rst_n = 1'b1;
        idle(10);
        send(8'h48, 1'b1, 1'b1);
        idle(20);
        check("t1_del", n_del, 1);
        check("t1_val_1cyc", val_hi, 1);
        check("t1_fe", fe_hi, 0);
        check("t1_ovr", 32'(bus.overrun_o), 32'd0);
        for (int i = 0; i < 3; i++)
            send(8'h48, 1'b1, 1'b1);
        idle(20);
        check("t2_del", n_del, 4);
        check("t2_fe", fe_hi, 0);
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(600);
        check("t3_del", n_del, 4);
        check("t3_val", val_hi, 4);
        check("t3_fe", fe_hi, 0);
        send(8'hA5, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        check("t4_fe_1cyc", fe_hi, 1);
        check("t4_del", n_del, 4);
        check("t4_val", 32'(bus.data_val_o), 32'd0);
        idle(50);
        send(8'h3C, 1'b1, 1'b1);
        idle(20);
        check("t4_recover", n_del, 5);
        check("t4_fe_after", fe_hi, 1);
        bus.data_rdy_i = 1'b0;
        send(8'h11, 1'b1, 1'b1);
        idle(20);
        check("t5_val", 32'(bus.data_val_o), 32'd1);
        check("t5_data1", 32'(bus.data_out), 32'h11);
        check("t5_ovr0", 32'(bus.overrun_o), 32'd0);
        send(8'h22, 1'b1, 1'b0);
        idle(20);
        check("t5_ovr1", 32'(bus.overrun_o), 32'd1);
        check("t5_data_kept", 32'(bus.data_out), 32'h11);
        bus.data_rdy_i = 1'b1;
        idle(3);
        check("t5_val_clr", 32'(bus.data_val_o), 32'd0);
        check("t5_ovr_sticky", 32'(bus.overrun_o), 32'd1);
        check("t5_del", n_del, 6);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1);
        rx = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_val", 32'(bus.data_val_o), 32'd0);
        check("t6_rst_data", 32'(bus.data_out), 32'h00);
        check("t6_rst_ovr", 32'(bus.overrun_o), 32'd0);
        check("t6_rst_fe", 32'(bus.frame_err_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5 * BD);
        check("t6_no_partial", n_del, 6);
        send(8'h5A, 1'b1, 1'b1);
        idle(20);
        check("t6_del", n_del, 7);
        check("t6_data", 32'(bus.data_out), 32'h5A);
`ifdef UART_RX_MAJORITY_EN
        sb.push_back(8'hFF);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            glitch_one();
        drive_bit(1'b1);
        idle(20);
        check("maj_del", n_del, 8);
        check("maj_data", 32'(bus.data_out), 32'hFF);
        check("maj_fe", fe_hi, 1);
`endif
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
